// File: rtl/tiny_shader_pkg.sv
// Shared types for the VGA output stage: pixel colour, sync flag bundle and its idle value.
`default_nettype none

package tiny_shader_pkg;

  localparam int COLOR_W = 6;

  typedef logic [COLOR_W-1:0] rgb_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblank;
    logic vblank;
  } sync_flags_t;

  localparam sync_flags_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, hblank: 1'b1, vblank: 1'b1};

endpackage

`default_nettype wire

// File: rtl/delay_line.sv
// Enable-gated shift register with asynchronous reset to RESET_VAL; DEPTH=0 is a plain wire.
`default_nettype none

module delay_line #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, reset_n, enable};
      assign dout        = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
        end else if (enable) begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_output_stage.sv
// Final VGA stage: aligns sync/blank flags with shader colour, drives registered pad outputs,
// line/frame start strobes and a free-running visible-frame counter.
`default_nettype none

module vga_output_stage #(
  parameter int   LATENCY    = 2,
  parameter int   COLOR_W    = tiny_shader_pkg::COLOR_W,
  parameter int   FRAME_W    = 16,
  parameter logic HSYNC_IDLE = 1'b1,
  parameter logic VSYNC_IDLE = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               hsync_in,
  input  logic               hblank_in,
  input  logic               vsync_in,
  input  logic               vblank_in,
  input  logic [COLOR_W-1:0] pixel_in,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] rgb,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  import tiny_shader_pkg::*;

  localparam sync_flags_t RST_FLAGS = '{hsync: HSYNC_IDLE, vsync: VSYNC_IDLE,
                                        hblank: SYNC_IDLE.hblank, vblank: SYNC_IDLE.vblank};

  sync_flags_t flags_in;
  sync_flags_t flags_d;
  logic        visible;
  logic        hb_p;
  logic        vb_p;

  assign flags_in = '{hsync: hsync_in, vsync: vsync_in, hblank: hblank_in, vblank: vblank_in};

  delay_line #(
    .WIDTH     ($bits(sync_flags_t)),
    .DEPTH     (LATENCY),
    .RESET_VAL (RST_FLAGS)
  ) u_flag_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .din     (flags_in),
    .dout    (flags_d)
  );

  assign visible = ~flags_d.hblank & ~flags_d.vblank;

  // vb_p stays set from vblank until the first visible pixel, so a vblank fall that lands
  // inside hblank still produces frame_start at the first visible pixel of the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= HSYNC_IDLE;
      vsync       <= VSYNC_IDLE;
      de          <= 1'b0;
      rgb         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      hb_p        <= 1'b1;
      vb_p        <= 1'b1;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (enable) begin
        hsync       <= flags_d.hsync;
        vsync       <= flags_d.vsync;
        de          <= visible;
        rgb         <= visible ? pixel_in : '0;
        line_start  <= visible & hb_p;
        frame_start <= visible & vb_p;
        if (visible && vb_p) frame_count <= frame_count + 1'b1;
        hb_p        <= flags_d.hblank;
        vb_p        <= flags_d.vblank | (vb_p & flags_d.hblank);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_output_stage.sv
// Scoreboard bench for vga_output_stage on a miniature 28x9 raster, LATENCY 2 and 0, FRAME_W 2 wrap.
`default_nettype none

module tb_vga_output_stage;

  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } fl_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [5:0]  rgb;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  localparam fl_t  IDLE_FL  = '{hs: 1'b1, vs: 1'b1, hb: 1'b1, vb: 1'b1};
  localparam exp_t IDLE_EXP = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 6'h0, ls: 1'b0, fs: 1'b0, fc: 16'h0};
  localparam int   FRAME_CLKS = 28 * 9;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b0;
  logic       hsync_in = 1'b1, hblank_in = 1'b1, vsync_in = 1'b1, vblank_in = 1'b1;
  logic [5:0] pixel_in = '0;

  logic        hsync, vsync, de, line_start, frame_start;
  logic [5:0]  rgb;
  logic [15:0] frame_count;
  logic        hsync0, vsync0, de0, line_start0, frame_start0;
  logic [5:0]  rgb0;
  logic [15:0] frame_count0;
  logic        hsyncw, vsyncw, dew, line_startw, frame_startw;
  logic [5:0]  rgbw;
  logic [1:0]  frame_countw;

  vga_output_stage #(.LATENCY(2), .COLOR_W(6), .FRAME_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .hsync_in(hsync_in), .hblank_in(hblank_in),
    .vsync_in(vsync_in), .vblank_in(vblank_in), .pixel_in(pixel_in), .hsync(hsync), .vsync(vsync),
    .de(de), .rgb(rgb), .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count));

  vga_output_stage #(.LATENCY(0), .COLOR_W(6), .FRAME_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .hsync_in(hsync_in), .hblank_in(hblank_in),
    .vsync_in(vsync_in), .vblank_in(vblank_in), .pixel_in(pixel_in), .hsync(hsync0), .vsync(vsync0),
    .de(de0), .rgb(rgb0), .line_start(line_start0), .frame_start(frame_start0), .frame_count(frame_count0));

  vga_output_stage #(.LATENCY(2), .COLOR_W(6), .FRAME_W(2)) dutw (
    .clk(clk), .reset_n(reset_n), .enable(enable), .hsync_in(hsync_in), .hblank_in(hblank_in),
    .vsync_in(vsync_in), .vblank_in(vblank_in), .pixel_in(pixel_in), .hsync(hsyncw), .vsync(vsyncw),
    .de(dew), .rgb(rgbw), .line_start(line_startw), .frame_start(frame_startw), .frame_count(frame_countw));

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   x = 0, y = 0;
  int   ls_cnt = 0, fs_cnt = 0;
  fl_t  hist[$];
  exp_t exp_q[$];
  exp_t exp0_q[$];
  exp_t last_e[2];
  logic hbp[2];
  logic vpend[2];
  logic [15:0] fcm[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic fl_t raster_flags(input int cx, input int cy);
    fl_t f;
    f.hb = (cx >= 16);
    f.hs = !(cx >= 20 && cx < 24);
    f.vb = (cy >= 6);
    f.vs = !(cy == 7);
    return f;
  endfunction

  task automatic model(input int i, input fl_t f, input logic [5:0] pix, output exp_t e);
    logic vis;
    vis   = !f.hb && !f.vb;
    e.hs  = f.hs;
    e.vs  = f.vs;
    e.de  = vis;
    e.rgb = vis ? pix : 6'h0;
    e.ls  = vis && hbp[i];
    e.fs  = vis && vpend[i];
    if (e.fs) fcm[i] = fcm[i] + 16'd1;
    e.fc     = fcm[i];
    hbp[i]   = f.hb;
    vpend[i] = f.vb ? 1'b1 : (vis ? 1'b0 : vpend[i]);
  endtask

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    exp0_q.delete();
    for (int i = 0; i < 2; i++) begin
      hbp[i] = 1'b1; vpend[i] = 1'b1; fcm[i] = '0; last_e[i] = IDLE_EXP;
    end
    x = 0; y = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hs"}, hsync, 1'b1);
    check({tag, "_vs"}, vsync, 1'b1);
    check({tag, "_de"}, de, 1'b0);
    check({tag, "_rgb"}, rgb, 6'h0);
    check({tag, "_pulses"}, {line_start, frame_start}, 2'b00);
    check({tag, "_fc"}, frame_count, 16'h0);
    check({tag, "_fcw"}, frame_countw, 2'h0);
    check({tag, "_hs0"}, hsync0, 1'b1);
  endtask

  task automatic reset_phase(input int cycles);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_idle("rst_now");
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      enable = 1'b1;
      {hsync_in, hblank_in, vsync_in, vblank_in} = 4'($urandom);
      pixel_in = 6'($urandom);
      @(posedge clk);
      #1 check_idle("rst_hold");
    end
    @(negedge clk);
    enable  = 1'b0;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit en);
    fl_t  cur;
    fl_t  f2;
    exp_t e;
    exp_t e0;
    int   n;
    @(negedge clk);
    cur = raster_flags(x, y);
    hsync_in  = cur.hs;
    hblank_in = cur.hb;
    vsync_in  = cur.vs;
    vblank_in = cur.vb;
    pixel_in  = 6'($urandom);
    enable    = en;
    if (en) begin
      hist.push_back(cur);
      n  = hist.size();
      f2 = (n >= 3) ? hist[n-3] : IDLE_FL;
      model(0, f2, pixel_in, e);
      exp_q.push_back(e);
      model(1, cur, pixel_in, e0);
      exp0_q.push_back(e0);
      if (hist.size() > 3) void'(hist.pop_front());
      x = (x == 27) ? 0 : x + 1;
      if (x == 20) y = (y == 8) ? 0 : y + 1;
    end
    @(posedge clk);
    #1;
    if (en) begin
      e  = exp_q.pop_front();
      e0 = exp0_q.pop_front();
      last_e[0] = e;
      last_e[1] = e0;
    end else begin
      e  = last_e[0]; e.ls = 1'b0;  e.fs = 1'b0;
      e0 = last_e[1]; e0.ls = 1'b0; e0.fs = 1'b0;
    end
    check("l2_sync", {hsync, vsync}, {e.hs, e.vs});
    check("l2_de", de, e.de);
    check("l2_rgb", rgb, e.rgb);
    check("l2_pulses", {line_start, frame_start}, {e.ls, e.fs});
    check("l2_fc", frame_count, e.fc);
    check("fs_implies_ls", frame_start & ~line_start, 1'b0);
    check("w_fc", frame_countw, e.fc[1:0]);
    check("l0_sync", {hsync0, vsync0}, {e0.hs, e0.vs});
    check("l0_de_rgb", {de0, rgb0}, {e0.de, e0.rgb});
    check("l0_pulses", {line_start0, frame_start0}, {e0.ls, e0.fs});
    if (line_start)  ls_cnt++;
    if (frame_start) fs_cnt++;
  endtask

  initial begin
    model_reset();
    reset_phase(4);
    for (int i = 0; i < 130; i++) step(1'b1);
    reset_phase(3);

    ls_cnt = 0;
    fs_cnt = 0;
    for (int i = 0; i < 3 * FRAME_CLKS; i++) step(1'b1);
    check("frames3_fs_count", fs_cnt, 3);
    check("frames3_ls_count", ls_cnt, 3 * 6);
    check("frames3_fc", frame_count, 16'd3);

    for (int i = 0; i < 2 * FRAME_CLKS; i++) step(1'b1);
    check("frames5_fc", frame_count, 16'd5);
    check("frames5_wrap_fc", frame_countw, 2'd1);

    for (int i = 0; i < 4 * FRAME_CLKS; i++) step((i % 4) == 0);
    check("gated_fc", frame_count, 16'd6);
    check("gated_fs_count", fs_cnt, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
